mips_mdu_iterative: RTL
=======================

# mips_mdu_iterative

Parametrised multi-cycle multiply/divide unit with integrated HI/LO registers, the sequential successor to the combinational multiplier, divider and HI/LO pair in the single-cycle core. It accepts one operation per start pulse and computes it with a radix-2 shift-add or restoring-divide loop of WIDTH iterations. While the operation runs it raises `busy` so the pipeline or multi-cycle controller can stall `mfhi`/`mflo`. It sits between the register file read ports and the write-back mux.

## Interface
- `WIDTH`, 32: operand, HI and LO width.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived; do not override).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: operation request, sampled only when `busy`=0.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved (ignored).
- `src_a` in WIDTH: rs value (multiplier/dividend/move source).
- `src_b` in WIDTH: rt value (multiplicand/divisor).
- `flush` in 1: synchronous abort of the in-flight operation.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `div_by_zero` out 1: last completed divide had `src_b`=0; cleared by the next accepted start.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE + start, op 0–3:**
  - Latch the operand magnitudes (two's-complement negate for signed ops with a negative operand).
  - Latch the result-sign bits and the op.
  - Clear the counter and enter CALC.
- **IDLE + start, op 4/5:** Write `src_a` to HI/LO at that edge, pulse `done` the next cycle, stay in IDLE, never assert `busy`.
- **CALC multiply:**
  - 2·WIDTH-bit accumulator.
  - Each cycle: if multiplier LSB = 1, add the multiplicand to the upper half, then shift right one.
- **CALC divide:**
  - Restoring algorithm; each cycle, shift the remainder:quotient pair left one.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit 0.
- **CALC exit:** after WIDTH iterations, go to FIX.
- **FIX:**
  - Apply sign correction.
    - Product is negated if the operand signs differ (signed only).
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - Write HI/LO (HI = product upper or remainder; LO = product lower or quotient).
  - Assert `done`, return to IDLE.
- **Divide by zero:**
  - Bypasses the loop result: LO = all ones, HI = dividend as given (`src_a`), `div_by_zero`=1.
  - Latency is unchanged.
- **Signed overflow:** DIV of most-negative by −1 gives LO = most-negative, HI = 0. This falls out naturally from the unsigned WIDTH-bit magnitudes.
- **start while busy:** ignored, no queueing.
- **flush:** in CALC/FIX, go to IDLE next edge. HI/LO and `div_by_zero` are unchanged, no `done`. In IDLE, `flush` has priority over `start`.
- **Reserved op:** ignored; nothing changes.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0, counter 0.
- **Reset mid-operation:** immediate return to those values, asynchronously.
- **Start accepted at edge 0:** `busy`=1 after edge 0.
- **CALC:** occupies edges 1..WIDTH.
- **FIX edge (WIDTH+1):**
  - HI/LO update.
  - `done`=1 and `busy`=0 after this edge.
  - `done` lasts exactly one cycle.
- **Latency:** WIDTH+1 cycles from the start edge to a valid result (33 at WIDTH=32).
- **Back-to-back starts:** a new start is accepted in the same cycle `done` is high. Throughput is one operation per WIDTH+2 cycles.
- **MTHI/MTLO:** written at the start edge; `done` high the following cycle.
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Structure
- **Shared package `mips_pkg`:** op encodings (`MDU_MULT`…`MDU_MTLO`) and state encodings (`MDU_IDLE`, `MDU_CALC`, `MDU_FIX`).
- **Sub-module `mdu_shift_core`:**
  - Holds the 2·WIDTH accumulator and performs one add-or-subtract-and-shift step per cycle under a `mode` bit.
  - The top level keeps the FSM, counter, sign handling, HI/LO and flags.

## Test plan
1. MULT `src_a`=0xFFFFFFFD (−3), `src_b`=7 → after 33 cycles `done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` high for exactly 33 cycles.
2. MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
3. DIV −7 (0xFFFFFFF9) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU 7/2 → LO=3, HI=1.
4. DIVU 5/0 → LO=0xFFFFFFFF, HI=5, `div_by_zero`=1. The next MULT start clears it. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
5. MTHI 0x12345678 → HI updated at the start edge, `done` next cycle, `busy` never 1. A start pulsed mid-MULT is ignored; the result matches the first op only.
6. `flush` at cycle 10 of a DIV → IDLE, HI/LO unchanged, no `done`. `reset` asserted mid-MULT → HI=LO=0, `busy`=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
package mips_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mips_mdu_iterative_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mips_mdu_iterative_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo, div_by_zero
    );

endinterface

// File: rtl/mdu_shift_core.sv
// 2*WIDTH accumulator doing one shift-add (mode=0) or restoring-divide (mode=1) step per cycle.
module mdu_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               step,
    input  logic               mode,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    always_comb begin
        acc_d  = acc_q;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        // shifted remainder needs one extra bit before the trial subtract
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand};
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, load_val};
        end else if (step) begin
            if (!mode) begin
                if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
                else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end else begin
                if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/mips_mdu_iterative.sv
// Multi-cycle MULT/DIV unit with HI/LO; FSM, counter, sign handling and flags around mdu_shift_core.
//   state    | meaning
//   MDU_IDLE | waiting for start; MTHI/MTLO complete here
//   MDU_CALC | WIDTH iterations of the shift core
//   MDU_FIX  | sign correction, HI/LO write, done pulse
module mips_mdu_iterative
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic            clk,
    input logic            reset,
    mips_mdu_iterative_if.slave mdu
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_by_zero_q, div_by_zero_d;

    logic               core_load, core_step;
    logic [2*WIDTH-1:0] acc;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    mdu_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .load_val (a_mag),
        .step     (core_step),
        .mode     (mode_q),
        .operand  (b_mag_q),
        .acc      (acc)
    );

    always_comb begin
        a_neg    = op_is_signed(mdu.op) && mdu.src_a[WIDTH-1];
        b_neg    = op_is_signed(mdu.op) && mdu.src_b[WIDTH-1];
        a_mag    = a_neg ? -mdu.src_a : mdu.src_a;
        b_mag    = b_neg ? -mdu.src_b : mdu.src_b;
        prod_fix = neg_res_q ? -acc : acc;
        quot_fix = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        neg_res_d     = neg_res_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        a_raw_d       = a_raw_q;
        b_mag_d       = b_mag_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;
        core_load     = 1'b0;
        core_step     = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (!mdu.flush && mdu.start) begin
                    case (mdu.op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            mode_d        = op_is_div(mdu.op);
                            neg_res_d     = a_neg ^ b_neg;
                            neg_rem_d     = a_neg;
                            dbz_d         = op_is_div(mdu.op) && (mdu.src_b == '0);
                            a_raw_d       = mdu.src_a;
                            b_mag_d       = b_mag;
                            cnt_d         = '0;
                            core_load     = 1'b1;
                            busy_d        = 1'b1;
                            div_by_zero_d = 1'b0;
                            state_d       = MDU_CALC;
                        end
                        MDU_MTHI: begin
                            hi_d          = mdu.src_a;
                            done_d        = 1'b1;
                            div_by_zero_d = 1'b0;
                        end
                        MDU_MTLO: begin
                            lo_d          = mdu.src_a;
                            done_d        = 1'b1;
                            div_by_zero_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            MDU_CALC: begin
                if (mdu.flush) begin
                    busy_d  = 1'b0;
                    state_d = MDU_IDLE;
                end else begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                busy_d  = 1'b0;
                state_d = MDU_IDLE;
                if (!mdu.flush) begin
                    done_d = 1'b1;
                    if (dbz_q) begin
                        // divide by zero ignores the loop result entirely
                        hi_d          = a_raw_q;
                        lo_d          = '1;
                        div_by_zero_d = 1'b1;
                    end else if (mode_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= MDU_IDLE;
            cnt_q         <= '0;
            mode_q        <= 1'b0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            a_raw_q       <= '0;
            b_mag_q       <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            neg_res_q     <= neg_res_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            a_raw_q       <= a_raw_d;
            b_mag_q       <= b_mag_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign mdu.busy        = busy_q;
    assign mdu.done        = done_q;
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;
    assign mdu.div_by_zero = div_by_zero_q;

endmodule
